// File: rtl/control_state_sequencer.sv
// Microstep sequencer for the multicycle CPU: decodes IR in ID, waits on the memory
// handshake, counts retired instructions and latches the halt condition.
module control_state_sequencer #(
  parameter int WORD_SIZE   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_SIZE-1:0]   inst,
  input  logic                   mem_ready,
  output logic [4:0]             state,
  output logic [COUNT_WIDTH-1:0] num_inst,
  output logic                   inst_done,
  output logic                   is_halted
);

  typedef enum logic [4:0] {
    ST_RESET  = 5'd0,
    ST_IF     = 5'd1,
    ST_ID     = 5'd2,
    ST_EX_R   = 5'd8,
    ST_EX_I   = 5'd9,
    ST_EX_MEM = 5'd10,
    ST_EX_BR  = 5'd11,
    ST_EX_J   = 5'd12,
    ST_MEM_RD = 5'd14,
    ST_MEM_WR = 5'd15,
    ST_WB_MEM = 5'd17,
    ST_WB     = 5'd18,
    ST_HALT   = 5'd20
  } state_t;

  localparam logic [3:0] OP_BR_LAST  = 4'd3;
  localparam logic [3:0] OP_IMM_LAST = 4'd6;
  localparam logic [3:0] OP_LWD      = 4'd7;
  localparam logic [3:0] OP_SWD      = 4'd8;
  localparam logic [3:0] OP_JMP      = 4'd9;
  localparam logic [3:0] OP_JAL      = 4'd10;
  localparam logic [3:0] OP_RTYPE    = 4'd15;
  localparam logic [5:0] FN_JPR      = 6'd25;
  localparam logic [5:0] FN_JRL      = 6'd26;
  localparam logic [5:0] FN_HLT      = 6'd29;

  state_t                 state_q;
  state_t                 state_d;
  logic [3:0]             op_q;
  logic [5:0]             func_q;
  logic [3:0]             op_id;
  logic [5:0]             func_id;
  logic                   retire;
  logic                   halt_set;
  logic                   unused_inst_bits;

  function automatic logic is_alu_r(input logic [3:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn[5:3] == 3'd0);
  endfunction

  assign op_id            = inst[WORD_SIZE-1 -: 4];
  assign func_id          = inst[5:0];
  assign unused_inst_bits = ^inst[WORD_SIZE-5:6];

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    halt_set = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IF;
      ST_IF:    if (mem_ready) state_d = ST_ID;
      ST_ID: begin
        if (op_id == OP_RTYPE) begin
          if (is_alu_r(op_id, func_id)) begin
            state_d = ST_EX_R;
          end else if (func_id == FN_JPR || func_id == FN_JRL) begin
            state_d = ST_EX_J;
          end else if (func_id == FN_HLT) begin
            state_d  = ST_HALT;
            retire   = 1'b1;
            halt_set = 1'b1;
          end else begin
            // WWD and undefined funcs retire straight from ID
            state_d = ST_IF;
            retire  = 1'b1;
          end
        end else if (op_id <= OP_BR_LAST) begin
          state_d = ST_EX_BR;
        end else if (op_id <= OP_IMM_LAST) begin
          state_d = ST_EX_I;
        end else if (op_id == OP_LWD || op_id == OP_SWD) begin
          state_d = ST_EX_MEM;
        end else if (op_id == OP_JMP || op_id == OP_JAL) begin
          state_d = ST_EX_J;
        end else begin
          state_d = ST_IF;
          retire  = 1'b1;
        end
      end
      // Later states see only the copy latched in ID; an inconsistent copy recovers via RESET
      ST_EX_R:   state_d = is_alu_r(op_q, func_q) ? ST_WB : ST_RESET;
      ST_EX_I:   state_d = ST_WB;
      ST_EX_MEM: state_d = (op_q == OP_LWD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d = ST_IF;
          retire  = 1'b1;
        end
      end
      ST_WB, ST_WB_MEM, ST_EX_BR, ST_EX_J: begin
        state_d = ST_IF;
        retire  = 1'b1;
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET;
      op_q      <= 4'd0;
      func_q    <= 6'd0;
      num_inst  <= '0;
      inst_done <= 1'b0;
      is_halted <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_done <= retire;
      if (retire) num_inst <= num_inst + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      if (halt_set) is_halted <= 1'b1;
      if (state_q == ST_ID) begin
        op_q   <= op_id;
        func_q <= func_id;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_state_sequencer.sv
// Bench for control_state_sequencer: random instruction streams with random memory
// stalls, checked cycle by cycle against a per-instruction state-path model.
module tb_control_state_sequencer;

  localparam int S_RESET = 0, S_IF = 1, S_ID = 2, S_EX_R = 8, S_EX_I = 9, S_EX_MEM = 10;
  localparam int S_EX_BR = 11, S_EX_J = 12, S_MEM_RD = 14, S_MEM_WR = 15;
  localparam int S_WB_MEM = 17, S_WB = 18, S_HALT = 20;
  localparam int C_ALU = 0, C_IMM = 1, C_LWD = 2, C_SWD = 3, C_BR = 4, C_JMP = 5;
  localparam int C_NOP = 6, C_HLT = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst;
  logic        mem_ready;
  logic [4:0]  state, state_w;
  logic [15:0] num_inst;
  logic [3:0]  num_inst_w;
  logic        inst_done, inst_done_w, is_halted, is_halted_w;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit exp_halted = 1'b0;

  always #5 clk = ~clk;

  control_state_sequencer dut (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
    .state(state), .num_inst(num_inst), .inst_done(inst_done), .is_halted(is_halted)
  );

  // Narrow-counter copy so counter wrap is reachable within a short run
  control_state_sequencer #(.COUNT_WIDTH(4)) dut_w (
    .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
    .state(state_w), .num_inst(num_inst_w), .inst_done(inst_done_w), .is_halted(is_halted_w)
  );

  function automatic int cls_of(input logic [15:0] w);
    int op = int'(w[15:12]);
    int fn = int'(w[5:0]);
    if (op == 15) begin
      if (fn <= 7) return C_ALU;
      if (fn == 25 || fn == 26) return C_JMP;
      if (fn == 29) return C_HLT;
      return C_NOP;
    end
    if (op <= 3) return C_BR;
    if (op <= 6) return C_IMM;
    if (op == 7) return C_LWD;
    if (op == 8) return C_SWD;
    if (op == 9 || op == 10) return C_JMP;
    return C_NOP;
  endfunction

  function automatic logic [15:0] rand_inst();
    logic [15:0] w = 16'($urandom);
    int k = $urandom_range(0, 9);
    if (k < 3) begin
      w[15:12] = 4'hF;
      w[5:0]   = 6'($urandom_range(0, 7));
    end else if (k == 3) begin
      w[15:12] = 4'hF;
      w[5:0]   = ($urandom_range(0, 1) != 0) ? 6'd25 : 6'd26;
    end
    if (w[15:12] == 4'hF && w[5:0] == 6'd29) w[5:0] = 6'd28;
    return w;
  endfunction

  task automatic check_all(input string name, input logic [4:0] es, input bit ed);
    checks++;
    if (state !== es || inst_done !== ed || num_inst !== 16'(exp_count) || is_halted !== exp_halted) begin
      errors++;
      $display("FAIL %s t=%0t: state=%0d done=%0b num=%0d halt=%0b, required state=%0d done=%0b num=%0d halt=%0b",
               name, $time, state, inst_done, num_inst, is_halted, es, ed, exp_count, exp_halted);
    end
    checks++;
    if (state_w !== es || inst_done_w !== ed || num_inst_w !== 4'(exp_count) || is_halted_w !== exp_halted) begin
      errors++;
      $display("FAIL %s_narrow t=%0t: state=%0d done=%0b num=%0d halt=%0b, required state=%0d done=%0b num=%0d halt=%0b",
               name, $time, state_w, inst_done_w, num_inst_w, is_halted_w, es, ed, exp_count % 16, exp_halted);
    end
  endtask

  // Runs one instruction starting from IF; wif/wmem are stall cycles in IF and MEM_RD/MEM_WR
  task automatic run_inst(input string name, input logic [15:0] w, input int wif, input int wmem);
    int q[$];
    int c;
    bit last;
    c = cls_of(w);
    for (int i = 0; i <= wif; i++) q.push_back(S_IF);
    q.push_back(S_ID);
    case (c)
      C_ALU: begin q.push_back(S_EX_R); q.push_back(S_WB); end
      C_IMM: begin q.push_back(S_EX_I); q.push_back(S_WB); end
      C_LWD: begin
        q.push_back(S_EX_MEM);
        for (int i = 0; i <= wmem; i++) q.push_back(S_MEM_RD);
        q.push_back(S_WB_MEM);
      end
      C_SWD: begin
        q.push_back(S_EX_MEM);
        for (int i = 0; i <= wmem; i++) q.push_back(S_MEM_WR);
      end
      C_BR:  q.push_back(S_EX_BR);
      C_JMP: q.push_back(S_EX_J);
      C_HLT: q.push_back(S_HALT);
      default: ;
    endcase
    if (c != C_HLT) q.push_back(S_IF);
    inst = w;
    for (int i = 0; i < q.size() - 1; i++) begin
      @(negedge clk);
      if (q[i] == S_IF || q[i] == S_MEM_RD || q[i] == S_MEM_WR) mem_ready = (q[i+1] != q[i]);
      else mem_ready = ($urandom_range(0, 1) != 0);
      if (q[i] != S_IF && q[i] != S_ID) inst = 16'($urandom);
      @(posedge clk);
      #1;
      last = (i == q.size() - 2);
      if (last) begin
        exp_count++;
        if (c == C_HLT) exp_halted = 1'b1;
      end
      check_all(name, 5'(q[i+1]), last);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = ($urandom_range(0, 1) != 0);
    exp_count = 0;
    exp_halted = 1'b0;
    #1;
    check_all("reset_async", 5'(S_RESET), 1'b0);
    @(posedge clk);
    #1;
    check_all("reset_hold", 5'(S_RESET), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset_to_if", 5'(S_IF), 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu();
    run_inst("alu_add", 16'hF000, 0, 0);
    run_inst("imm_adi", 16'h4A55, 0, 0);
  endtask

  task automatic test_lwd_wait();
    run_inst("lwd_wait", 16'h7123, 0, 2);
    run_inst("swd_wait", 16'h8123, 1, 3);
  endtask

  task automatic test_mixed();
    do_reset();
    run_inst("mix_swd", 16'h8042, 0, 0);
    run_inst("mix_beq", 16'h1042, 0, 0);
    run_inst("mix_jal", 16'hA042, 0, 0);
    checks++;
    if (num_inst !== 16'd3) begin
      errors++;
      $display("FAIL mix_count: num_inst=%0d required 3", num_inst);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      run_inst("random", rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 16 && (exp_count % 16) != 15; n++)
      run_inst("wrap_fill", 16'hF01C, $urandom_range(0, 1), 0);
    checks++;
    if (num_inst_w !== 4'hF) begin
      errors++;
      $display("FAIL wrap_preload: num_inst=%0h required f", num_inst_w);
    end
    run_inst("wrap_step", 16'hC000, 0, 0);
    checks++;
    if (num_inst_w !== 4'h0 || inst_done_w !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: num_inst=%0h done=%0b required 0 and 1", num_inst_w, inst_done_w);
    end
  endtask

  task automatic test_async_reset();
    inst = 16'hF001;
    @(negedge clk);
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("abort_in_ex_r", 5'(S_EX_R), 1'b0);
    #2;
    reset = 1'b1;
    exp_count = 0;
    exp_halted = 1'b0;
    #1;
    check_all("abort_async", 5'(S_RESET), 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("abort_resume", 5'(S_IF), 1'b0);
    run_inst("abort_next", 16'hF002, 0, 0);
  endtask

  task automatic test_halt();
    run_inst("halt", 16'hF01D, 1, 0);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      mem_ready = ($urandom_range(0, 1) != 0);
      inst = 16'($urandom);
      @(posedge clk);
      #1;
      check_all("halt_stay", 5'(S_HALT), 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst = 16'h0000;
    mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_lwd_wait();
    test_mixed();
    test_random();
    test_wrap();
    test_async_reset();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_state_sequencer.md
# control_state_sequencer

Next-state engine for the multicycle CPU: it tracks the current microstep, decodes the instruction in IR, and drives the 5-bit `state` vector that the control-signal decoder turns into datapath control. It also waits on the memory ready handshake, counts retired instructions, and latches the halt condition. It sits between the datapath (IR contents, memory ready) and the control-signal decoder.

## Interface
- `WORD_SIZE`, 16: instruction width. Opcode is `inst[15:12]`; func is `inst[5:0]`.
- `COUNT_WIDTH`, 16: width of the retired-instruction counter.
- `clk` input 1: the single clock; every state update happens on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `inst` input WORD_SIZE: current IR contents, stable from the cycle after IF completes.
- `mem_ready` input 1: memory access complete; sampled only in IF, MEM_RD and MEM_WR.
- `state` output 5: current control state, registered.
- `num_inst` output COUNT_WIDTH: retired-instruction count, registered.
- `inst_done` output 1: one-cycle pulse per retired instruction, registered.
- `is_halted` output 1: set once HLT is decoded; sticky.

## Operation
- State encodings, fixed and shared with the control-signal decoder:
  - RESET=0, IF=1, ID=2
  - EX_R=8, EX_I=9, EX_MEM=10, EX_BR=11, EX_J=12
  - MEM_RD=14, MEM_WR=15, WB_MEM=17, WB=18, HALT=20
  - All other codes are unused.
- Instruction classes:
  - ALU R-type: opcode 15, func 0–7.
  - WWD: opcode 15, func 28. JPR: opcode 15, func 25. JRL: opcode 15, func 26. HLT: opcode 15, func 29.
  - Branches: opcodes 0–3 (BNE, BEQ, BGZ, BLZ).
  - Immediate ALU: opcodes 4–6 (ADI, ORI, LHI).
  - LWD: opcode 7. SWD: opcode 8. JMP: opcode 9. JAL: opcode 10.
- In ID, opcode and func are latched into internal registers. All later states decode from the latched copy only.
- Transitions:
  - RESET → IF, unconditionally.
  - IF → ID when `mem_ready`=1; otherwise stay in IF.
  - ID → EX_R for ALU R-type; → EX_I for immediate ALU; → EX_MEM for LWD/SWD; → EX_BR for branches; → EX_J for JMP/JAL/JPR/JRL.
  - ID → IF for WWD and for undefined opcode/func. Both retire; an undefined instruction is a NOP.
  - ID → HALT for HLT. HLT retires.
  - EX_R → WB; EX_I → WB.
  - EX_MEM → MEM_RD if the latched opcode is LWD; → MEM_WR if it is SWD.
  - MEM_RD → WB_MEM when `mem_ready`=1; otherwise stay.
  - MEM_WR → IF when `mem_ready`=1 (retire); otherwise stay.
  - WB → IF, WB_MEM → IF, EX_BR → IF, EX_J → IF; each retires.
  - HALT → HALT until `reset`.
  - Any unused code → RESET (safety recovery; no retire).
- Retire event:
  - Occurs on every transition into IF from ID, MEM_WR, WB, WB_MEM, EX_BR or EX_J, and on the ID → HALT transition.
  - On that edge, `num_inst` increments by 1 and `inst_done` is set.
  - `num_inst` wraps from all-ones to 0 with no flag.
- `inst_done` is high for exactly the one cycle following a retire edge. It is cleared on the next edge unless another retire occurs.
- `is_halted` is set on the ID → HALT edge. It is cleared only by `reset`.
- `mem_ready` is ignored outside IF, MEM_RD and MEM_WR. A `mem_ready` pulse in any other state has no effect.

## Timing
- Reset values, asynchronous: `state`=RESET(0), `num_inst`=0, `inst_done`=0, `is_halted`=0, latched opcode/func=0.
- Reset mid-instruction aborts immediately: no retire and no partial count. After `reset` falls, the first edge moves RESET → IF.
- Cycle counts with `mem_ready` held at 1, counted from entry into IF to re-entry into IF:
  - ALU R-type and immediate ALU: 4 (IF, ID, EX, WB).
  - LWD: 5. SWD: 4.
  - Branch and jump: 3.
  - WWD and NOP: 2.
- Each cycle with `mem_ready`=0 in IF, MEM_RD or MEM_WR adds exactly one cycle.
- `state`, `num_inst` and `inst_done` all change on the same rising edge. None has a combinational path from any input.

## Test plan
- Reset, then an ADD in IR with `mem_ready`=1 → `state` sequence 0, 1, 2, 8, 18, 1; `inst_done` pulses once; `num_inst`=1.
- LWD with `mem_ready` held low for 2 cycles in MEM_RD → sequence 1, 2, 10, 14, 14, 14, 17, 1; 7 cycles total; `num_inst` increments by 1.
- SWD, then BEQ, then JAL → states 15, 11 and 12 visited in turn; `num_inst`=3; `inst_done` pulses on 3 distinct cycles.
- HLT → `state`=20 and stays there for 100 cycles; `is_halted`=1; `num_inst` increments once; `mem_ready` toggling has no effect.
- Preload `num_inst`=0xFFFF via 65535 WWDs (or force), then retire one more → `num_inst`=0x0000 and `inst_done`=1.
- Assert `reset` asynchronously mid-EX_R → `state`=0 and all outputs 0 before the next edge; after release, the sequence resumes at IF.
